// File: rtl/mb_sequencer.sv
// mb_sequencer -- microprogram sequencer for the Math Box.
//
// A CPU write launches a microprogram. The start address comes from an
// external start-map ROM (indexed by CPU_ADDR, answer on START_PC). Each
// microword takes two cycles: FETCH waits for the synchronous microcode ROM,
// and EXEC strobes the ALU and picks the next PC.
//
// Handshake: CPU_WR is a one-cycle strobe that is always accepted. In IDLE it
// starts a program. In FETCH/EXEC it restarts and wins over everything else in
// that cycle (STOP, watchdog). There is no back-pressure.
//
// Optional feature: define MB_WATCHDOG_EN to add a cycle watchdog that aborts
// a program after WD_LIMIT busy cycles without a STOP.
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   CPU_WR            command write strobe
//   CPU_ADDR          command select (only feeds the external start-map ROM)
//   CPU_DATA          operand byte, latched onto DIN
//   START_PC          start-map ROM output, valid in the CPU_WR cycle
//   ROM_ADDR          microcode ROM address (registered PC)
//   INSTR_STOP/JMP/COND/TGT  microword fields, valid one cycle after ROM_ADDR
//   Q0                ALU condition bit
//   DIN               latched operand
//   ALU_STB           ALU execute strobe (one per microword)
//   BUSY              program running
//   DONE              one-cycle completion pulse
//   ABORT             one-cycle watchdog pulse (0 without MB_WATCHDOG_EN)
module mb_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int SEL_W    = 5,
  parameter int WD_LIMIT = 1023
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CPU_WR,
  input  logic [SEL_W-1:0]  CPU_ADDR,
  input  logic [7:0]        CPU_DATA,
  input  logic [ADDR_W-1:0] START_PC,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic              INSTR_STOP,
  input  logic              INSTR_JMP,
  input  logic              INSTR_COND,
  input  logic [ADDR_W-1:0] INSTR_TGT,
  input  logic              Q0,
  output logic [7:0]        DIN,
  output logic              ALU_STB,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        din_q, din_d;
  logic              cond_q, cond_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              alu_stb;
  logic              taken;
  logic              wd_expire;

  // CPU_ADDR is consumed by the external start-map ROM, not by this block.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^CPU_ADDR;

`ifdef MB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // A STOP in the expiry cycle still completes normally. CPU_WR always wins.
  assign wd_expire = busy_q && (wd_q == WD_W'(WD_LIMIT)) && !CPU_WR &&
                     !((state_q == S_EXEC) && INSTR_STOP);

  always_comb begin
    wd_d = wd_q;
    if (CPU_WR)      wd_d = '0;
    else if (busy_q) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  localparam int unused_wd_limit = WD_LIMIT;
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    cond_d  = cond_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    alu_stb = 1'b0;
    taken   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CPU_WR) begin
          pc_d    = START_PC;
          din_d   = CPU_DATA;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (CPU_WR) begin
          pc_d    = START_PC;
          din_d   = CPU_DATA;
          cond_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (CPU_WR) begin
          // Restart: no strobe, no DONE for the abandoned program.
          pc_d    = START_PC;
          din_d   = CPU_DATA;
          cond_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          alu_stb = 1'b1;
          cond_d  = Q0;
          if (INSTR_STOP) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // A conditional jump is taken when the latched condition is low.
            taken   = INSTR_JMP & (~INSTR_COND | ~cond_q);
            pc_d    = taken ? INSTR_TGT : pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (wd_expire) begin
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      cond_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      cond_q  <= cond_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ROM_ADDR = pc_q;
  assign DIN      = din_q;
  assign ALU_STB  = alu_stb;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ABORT    = wd_expire;

endmodule

// File: tb/tb_mb_sequencer.sv
// Directed testbench for mb_sequencer with a behavioural synchronous
// microcode ROM (one-cycle latency) built from per-field arrays.
module tb_mb_sequencer;

  logic       CLK;
  logic       RESET_N;
  logic       CPU_WR;
  logic [4:0] CPU_ADDR;
  logic [7:0] CPU_DATA;
  logic [9:0] START_PC;
  logic [9:0] ROM_ADDR;
  logic       INSTR_STOP;
  logic       INSTR_JMP;
  logic       INSTR_COND;
  logic [9:0] INSTR_TGT;
  logic       Q0;
  logic [7:0] DIN;
  logic       ALU_STB;
  logic       BUSY;
  logic       DONE;
  logic       ABORT;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rom_stop [1024];
  logic       rom_jmp  [1024];
  logic       rom_cond [1024];
  logic [9:0] rom_tgt  [1024];

`ifdef MB_WATCHDOG_EN
  mb_sequencer #(.ADDR_W(10), .SEL_W(5), .WD_LIMIT(15)) dut (
`else
  mb_sequencer #(.ADDR_W(10), .SEL_W(5), .WD_LIMIT(1023)) dut (
`endif
    .CLK(CLK), .RESET_N(RESET_N), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA(CPU_DATA), .START_PC(START_PC), .ROM_ADDR(ROM_ADDR),
    .INSTR_STOP(INSTR_STOP), .INSTR_JMP(INSTR_JMP), .INSTR_COND(INSTR_COND),
    .INSTR_TGT(INSTR_TGT), .Q0(Q0), .DIN(DIN), .ALU_STB(ALU_STB),
    .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous microcode ROM
  always @(posedge CLK) begin
    INSTR_STOP <= rom_stop[ROM_ADDR];
    INSTR_JMP  <= rom_jmp[ROM_ADDR];
    INSTR_COND <= rom_cond[ROM_ADDR];
    INSTR_TGT  <= rom_tgt[ROM_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver: one-cycle CPU write, returns in the first FETCH cycle.
  task automatic cpu_write(input logic [9:0] pc, input logic [7:0] data);
    CPU_WR   = 1'b1;
    CPU_ADDR = pc[4:0];
    START_PC = pc;
    CPU_DATA = data;
    step();
    CPU_WR   = 1'b0;
  endtask

  // Bounded wait for the program to end; checks the number of DONE pulses seen.
  task automatic wait_idle(input string tag, input int exp_done);
    int d;
    d = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      step();
      if (DONE) d++;
    end
    check({tag, "_idle"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(d), 32'(exp_done));
  endtask

  initial begin
    int busy_cnt, stb_cnt, done_cnt, abort_cnt, lo_cnt, first_abort, first_lo;
    logic [9:0] exp_addr [6];

    for (int i = 0; i < 1024; i++) begin
      rom_stop[i] = 1'b0;
      rom_jmp[i]  = 1'b0;
      rom_cond[i] = 1'b0;
      rom_tgt[i]  = '0;
    end
    rom_stop[10'h102] = 1'b1;
    rom_jmp[10'h010]  = 1'b1;
    rom_cond[10'h010] = 1'b1;
    rom_tgt[10'h010]  = 10'h200;
    rom_stop[10'h200] = 1'b1;
    rom_stop[10'h011] = 1'b1;
    rom_stop[10'h000] = 1'b1;
    rom_stop[10'h080] = 1'b1;
    rom_jmp[10'h300]  = 1'b1;
    rom_tgt[10'h300]  = 10'h300;

    RESET_N  = 1'b0;
    CPU_WR   = 1'b0;
    CPU_ADDR = '0;
    CPU_DATA = '0;
    START_PC = '0;
    Q0       = 1'b0;

    // Reset state
    #12;
    check("rst_rom_addr", 32'(ROM_ADDR), 32'h0);
    check("rst_din", 32'(DIN), 32'h0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_stb", 32'(ALU_STB), 32'd0);
    check("rst_abort", 32'(ABORT), 32'd0);
    RESET_N = 1'b1;
    step();

    // Reset mid-run: program at 0x040, reset asserted during EXEC
    cpu_write(10'h040, 8'h77);
    step();
    check("midrun_stb_pre", 32'(ALU_STB), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("midrun_rom_addr", 32'(ROM_ADDR), 32'h0);
    check("midrun_din", 32'(DIN), 32'h0);
    check("midrun_busy", 32'(BUSY), 32'd0);
    check("midrun_stb", 32'(ALU_STB), 32'd0);
    check("midrun_done", 32'(DONE), 32'd0);
    #1 RESET_N = 1'b1;
    step();
    check("midrun_idle_busy", 32'(BUSY), 32'd0);
    check("midrun_idle_addr", 32'(ROM_ADDR), 32'h0);
    check("midrun_idle_stb", 32'(ALU_STB), 32'd0);

    // Linear program 0x100..0x102, STOP at 0x102
    exp_addr[0] = 10'h100; exp_addr[1] = 10'h100; exp_addr[2] = 10'h101;
    exp_addr[3] = 10'h101; exp_addr[4] = 10'h102; exp_addr[5] = 10'h102;
    busy_cnt = 0; stb_cnt = 0; done_cnt = 0;
    cpu_write(10'h100, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      if (ALU_STB) stb_cnt++;
      if (i < 6) begin
        check($sformatf("lin_addr_%0d", i), 32'(ROM_ADDR), 32'(exp_addr[i]));
        check($sformatf("lin_stb_%0d", i), 32'(ALU_STB), 32'(i % 2));
      end
      if (i == 6) begin
        check("lin_done_at_6", 32'(DONE), 32'd1);
        check("lin_addr_hold", 32'(ROM_ADDR), 32'h102);
      end
      step();
    end
    check("lin_busy_cycles", 32'(busy_cnt), 32'd6);
    check("lin_stb_count", 32'(stb_cnt), 32'd3);
    check("lin_done_count", 32'(done_cnt), 32'd1);
    check("lin_din", 32'(DIN), 32'h5A);
    check("lin_busy_end", 32'(BUSY), 32'd0);

    // Conditional jump, latched cond = 0 -> taken
    Q0 = 1'b0;
    cpu_write(10'h00F, 8'h11);
    for (int i = 0; i < 4; i++) step();
    check("cjmp_cond0", 32'(ROM_ADDR), 32'h200);
    wait_idle("cjmp0", 1);

    // Conditional jump, latched cond = 1 -> falls through
    Q0 = 1'b1;
    cpu_write(10'h00F, 8'h22);
    for (int i = 0; i < 4; i++) step();
    check("cjmp_cond1", 32'(ROM_ADDR), 32'h011);
    wait_idle("cjmp1", 1);

    // Unconditional jump ignores the latched condition
    rom_cond[10'h010] = 1'b0;
    cpu_write(10'h00F, 8'h33);
    for (int i = 0; i < 4; i++) step();
    check("ujmp", 32'(ROM_ADDR), 32'h200);
    wait_idle("ujmp", 1);
    Q0 = 1'b0;

    // PC wrap from 0x3FF to 0x000
    cpu_write(10'h3FF, 8'h44);
    step(); step();
    check("wrap_addr", 32'(ROM_ADDR), 32'h000);
    wait_idle("wrap", 1);

    // Restart while executing at 0x105
    cpu_write(10'h105, 8'h55);
    step();
    CPU_WR = 1'b1; START_PC = 10'h080; CPU_DATA = 8'hC3;
    #1;
    check("rst1_no_stb", 32'(ALU_STB), 32'd0);
    step();
    CPU_WR = 1'b0;
    check("rst1_addr", 32'(ROM_ADDR), 32'h080);
    check("rst1_busy", 32'(BUSY), 32'd1);
    check("rst1_done", 32'(DONE), 32'd0);
    check("rst1_din", 32'(DIN), 32'hC3);
    step();
    check("rst1_busy_exec", 32'(BUSY), 32'd1);
    wait_idle("rst1", 1);

    // Restart coincident with a STOP EXEC
    cpu_write(10'h102, 8'h66);
    step();
    CPU_WR = 1'b1; START_PC = 10'h080; CPU_DATA = 8'h99;
    #1;
    check("rst2_no_stb", 32'(ALU_STB), 32'd0);
    step();
    CPU_WR = 1'b0;
    check("rst2_done", 32'(DONE), 32'd0);
    check("rst2_busy", 32'(BUSY), 32'd1);
    check("rst2_addr", 32'(ROM_ADDR), 32'h080);
    step();
    check("rst2_stb_exec", 32'(ALU_STB), 32'd1);
    wait_idle("rst2", 1);

    // Jump-to-self loop: watchdog behaviour
    abort_cnt = 0; lo_cnt = 0; done_cnt = 0; first_abort = -1; first_lo = -1;
    cpu_write(10'h300, 8'h01);
`ifdef MB_WATCHDOG_EN
    for (int i = 0; i < 40; i++) begin
      if (ABORT) begin
        abort_cnt++;
        if (first_abort < 0) first_abort = i;
      end
      if (!BUSY && first_lo < 0) first_lo = i;
      if (DONE) done_cnt++;
      step();
    end
    check("wd_abort_count", 32'(abort_cnt), 32'd1);
    check("wd_abort_at", 32'(first_abort), 32'd15);
    check("wd_busy_low_at", 32'(first_lo), 32'd16);
    check("wd_no_done", 32'(done_cnt), 32'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (ABORT) abort_cnt++;
      if (!BUSY) lo_cnt++;
      if (DONE) done_cnt++;
      step();
    end
    check("nowd_abort", 32'(abort_cnt), 32'd0);
    check("nowd_busy_low", 32'(lo_cnt), 32'd0);
    check("nowd_no_done", 32'(done_cnt), 32'd0);
`endif
    RESET_N = 1'b0;
    #2 RESET_N = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
